// File: rtl/deser_arb_pkg.sv
// deser_arb_pkg: shared types, sizes and the round-robin pick helper for deser_arb.
package deser_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WORD_W    = 16;
    localparam int DRAIN_MAX = 4;
    localparam int MAX_CH    = 16;
    localparam int MAX_IDX_W = 4;

    // One-hot pick of the first set request at or above ptr, wrapping at n.
    function automatic logic [MAX_CH-1:0] rr_pick(
        input logic [MAX_CH-1:0]    req,
        input logic [MAX_IDX_W-1:0] ptr,
        input int                   n
    );
        logic [MAX_CH-1:0] pick;
        logic              found;
        int                idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n)
                idx = idx - n;
            if (i < n && !found && req[idx[MAX_IDX_W-1:0]]) begin
                pick[idx[MAX_IDX_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/deser_arb_if.sv
// deser_arb_if: per-channel serial request bus plus the word delivery outputs.
interface deser_arb_if
    import deser_arb_pkg::*;
#(
    parameter int CH_NUM = 4
);
    localparam int IDX_W = $clog2(CH_NUM);

    logic [CH_NUM-1:0] req_i;
    logic [CH_NUM-1:0] data_i;
    logic [CH_NUM-1:0] data_val_i;
    logic [CH_NUM-1:0] gnt_o;
    logic [WORD_W-1:0] word_o;
    logic [IDX_W-1:0]  word_ch_o;
    logic              word_val_o;
    logic              abort_o;

    modport master (
        output req_i, data_i, data_val_i,
        input  gnt_o, word_o, word_ch_o, word_val_o, abort_o
    );

    modport slave (
        input  req_i, data_i, data_val_i,
        output gnt_o, word_o, word_ch_o, word_val_o, abort_o
    );
endinterface

// File: rtl/deser_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick returning a one-hot grant and its index.
module rr_arbiter
    import deser_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);
    logic [MAX_CH-1:0] req_pad;
    logic [MAX_CH-1:0] pick;

    generate
        for (genvar gi = 0; gi < MAX_CH; gi++) begin : g_pad
            if (gi < N) begin : g_live
                assign req_pad[gi] = req[gi];
            end else begin : g_zero
                assign req_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign pick = rr_pick(req_pad, MAX_IDX_W'(ptr), N);
    assign gnt  = pick[N-1:0];

    // One-hot to binary encode of the picked channel.
    always_comb begin
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (pick[i])
                idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/deserializer.sv
// deserializer: collects 16 qualified bits MSB-first and presents the word with a one-cycle strobe.
module deserializer (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        data_i,
    input  logic        data_val_i,
    output logic [15:0] deser_data_o,
    output logic        deser_data_val_o
);
    logic [14:0] shift_reg;
    logic [3:0]  cnt_reg;

    // Shift in valid bits; the 16th bit completes the word and fires the strobe.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            shift_reg        <= '0;
            cnt_reg          <= '0;
            deser_data_o     <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            deser_data_val_o <= 1'b0;
            if (data_val_i) begin
                shift_reg <= {shift_reg[13:0], data_i};
                cnt_reg   <= cnt_reg + 4'd1;
                if (cnt_reg == 4'd15) begin
                    deser_data_o     <= {shift_reg, data_i};
                    deser_data_val_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/deser_arb.sv
// deser_arb: round-robin sharing of one 16-bit deserializer among CH_NUM serial requesters.
// Optional XFER idle watchdog enabled by defining DESER_ARB_TIMEOUT_EN.
module deser_arb
    import deser_arb_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        srst_i,
    deser_arb_if.slave  bus
);
    localparam int IDX_W = $clog2(CH_NUM);

    if (CH_NUM < 2 || CH_NUM > MAX_CH || TIMEOUT < 2) begin : g_param_check
        $error("deser_arb: CH_NUM or TIMEOUT out of range");
    end

    state_t              state_reg;
    logic [IDX_W-1:0]    ptr_reg;
    logic [IDX_W-1:0]    k_reg;
    logic [CH_NUM-1:0]   gnt_reg;
    logic [4:0]          bit_cnt_reg;
    logic [2:0]          drain_cnt_reg;
    logic [WORD_W-1:0]   word_reg;
    logic [IDX_W-1:0]    word_ch_reg;
    logic                word_val_reg;
    logic                abort_reg;
    logic                flush_reg;
`ifdef DESER_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT);
    logic [WD_W-1:0]     wdog_reg;
`endif

    logic [CH_NUM-1:0]   arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                deser_din;
    logic                deser_val;
    logic                deser_rst;
    logic [WORD_W-1:0]   deser_word;
    logic                deser_word_val;
    logic                bit_last;

    rr_arbiter #(.N(CH_NUM), .IDX_W(IDX_W)) u_arb (
        .req (bus.req_i),
        .ptr (ptr_reg),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Only the granted channel reaches the deserializer, and only while in XFER.
    assign deser_din = bus.data_i[k_reg];
    assign deser_val = (state_reg == XFER) && bus.data_val_i[k_reg];
    assign deser_rst = srst_i | flush_reg;
    assign bit_last  = (bit_cnt_reg == 5'(WORD_W - 1));

    deserializer u_deser (
        .clk_i            (clk_i),
        .srst_i           (deser_rst),
        .data_i           (deser_din),
        .data_val_i       (deser_val),
        .deser_data_o     (deser_word),
        .deser_data_val_o (deser_word_val)
    );

    // Scheduler FSM: grant, count bits, wait for the word, abort on stalls.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            k_reg         <= '0;
            gnt_reg       <= '0;
            bit_cnt_reg   <= '0;
            drain_cnt_reg <= '0;
            word_reg      <= '0;
            word_ch_reg   <= '0;
            word_val_reg  <= 1'b0;
            abort_reg     <= 1'b0;
            flush_reg     <= 1'b0;
`ifdef DESER_ARB_TIMEOUT_EN
            wdog_reg      <= '0;
`endif
        end else begin
            word_val_reg <= 1'b0;
            abort_reg    <= 1'b0;
            flush_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|bus.req_i) begin
                        gnt_reg     <= arb_gnt;
                        k_reg       <= arb_idx;
                        ptr_reg     <= (arb_idx == IDX_W'(CH_NUM - 1)) ? '0 : arb_idx + 1'b1;
                        bit_cnt_reg <= '0;
`ifdef DESER_ARB_TIMEOUT_EN
                        wdog_reg    <= '0;
`endif
                        state_reg   <= XFER;
                    end
                end
                XFER: begin
                    if (deser_val) begin
`ifdef DESER_ARB_TIMEOUT_EN
                        wdog_reg <= '0;
`endif
                        if (bit_last) begin
                            gnt_reg       <= '0;
                            bit_cnt_reg   <= '0;
                            drain_cnt_reg <= '0;
                            state_reg     <= DRAIN;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
`ifdef DESER_ARB_TIMEOUT_EN
                    else if (wdog_reg == WD_W'(TIMEOUT - 1)) begin
                        abort_reg   <= 1'b1;
                        flush_reg   <= 1'b1;
                        gnt_reg     <= '0;
                        bit_cnt_reg <= '0;
                        state_reg   <= IDLE;
                    end else begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (deser_word_val) begin
                        word_reg     <= deser_word;
                        word_ch_reg  <= k_reg;
                        word_val_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end else if (drain_cnt_reg == 3'(DRAIN_MAX - 1)) begin
                        abort_reg   <= 1'b1;
                        flush_reg   <= 1'b1;
                        gnt_reg     <= '0;
                        bit_cnt_reg <= '0;
                        state_reg   <= IDLE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 3'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o      = gnt_reg;
    assign bus.word_o     = word_reg;
    assign bus.word_ch_o  = word_ch_reg;
    assign bus.word_val_o = word_val_reg;
    assign bus.abort_o    = abort_reg;
endmodule

// File: tb/tb_deser_arb.sv
// tb_deser_arb: randomized self-checking bench for deser_arb with a transaction-level round-robin model.
// Exercises the watchdog abort when DESER_ARB_TIMEOUT_EN is defined, an indefinite stall otherwise.
module tb_deser_arb;
    import deser_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    deser_arb_if #(.CH_NUM(N)) bus();

    deser_arb #(.CH_NUM(N), .TIMEOUT(TO)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int mptr     = 0;
    logic [15:0] words [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first pending channel at or after the model pointer, with wrap.
    function automatic int model_pick(input logic [N-1:0] pend, input int p);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (p + i) % N;
            if (pend[c])
                return c;
        end
        return 0;
    endfunction

    task automatic do_reset();
        srst           = 1'b1;
        bus.req_i      = '0;
        bus.data_i     = '0;
        bus.data_val_i = '0;
        repeat (3) tick();
        srst = 1'b0;
        mptr = 0;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (bus.gnt_o == '0 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Stream bits [first, first+cnt) of w on channel k with random gaps; others optionally toggle garbage.
    task automatic send_bits(input int k, input logic [15:0] w, input int first, input int cnt, input bit noise);
        for (int i = first; i < first + cnt; i++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g <= gaps; g++) begin
                for (int c = 0; c < N; c++) begin
                    if (c == k) begin
                        bus.data_val_i[c] = (g == gaps);
                        bus.data_i[c]     = (g == gaps) ? w[15-i] : 1'($urandom_range(0, 1));
                    end else begin
                        bus.data_val_i[c] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                        bus.data_i[c]     = ~w[15-i];
                    end
                end
                tick();
            end
        end
        bus.data_val_i = '0;
    endtask

    // Called just after the edge that accepted the 16th bit.
    task automatic finish_word(input int k, input logic [15:0] w, input string tag);
        int lat;
        lat = 0;
        chk({tag, "_gnt_clr"}, 32'(bus.gnt_o), 32'd0);
        while (!bus.word_val_o && lat < 8) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat >= 1 && lat <= 3), 32'd1);
        chk({tag, "_word"}, 32'(bus.word_o), 32'(w));
        chk({tag, "_ch"}, 32'(bus.word_ch_o), 32'(k));
        $display("xfer %s: ch=%0d word=0x%04h latency=%0d", tag, bus.word_ch_o, bus.word_o, lat);
        tick();
        chk({tag, "_pulse"}, 32'(bus.word_val_o), 32'd0);
        chk({tag, "_hold"}, 32'(bus.word_o), 32'(w));
    endtask

    // Raise all requests in mask and serve them in model order.
    task automatic serve(input logic [N-1:0] mask, input bit noise, input string tag);
        logic [N-1:0] pend;
        int           n;
        int           k;
        bit           first;
        pend      = mask;
        bus.req_i = mask;
        first     = 1'b1;
        while (pend != '0) begin
            k = model_pick(pend, mptr);
            wait_gnt(n);
            if (first)
                chk({tag, "_gnt_lat"}, 32'(n), 32'd1);
            chk({tag, "_gnt"}, 32'(bus.gnt_o), 32'd1 << k);
            first        = 1'b0;
            bus.req_i[k] = 1'b0;
            pend[k]      = 1'b0;
            mptr         = (k + 1) % N;
            send_bits(k, words[k], 0, 16, noise);
            finish_word(k, words[k], tag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int          n;
        int          aborts;
        logic [N-1:0] mask;

        do_reset();
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst_word", 32'(bus.word_o), 32'd0);
        chk("rst_ch", 32'(bus.word_ch_o), 32'd0);
        chk("rst_val", 32'(bus.word_val_o), 32'd0);
        chk("rst_abort", 32'(bus.abort_o), 32'd0);

        // Single channel 2 transfer with random gaps.
        words[2] = 16'hA5C3;
        serve(4'b0100, 1'b0, "ch2");

        // All four at once after reset: order 0,1,2,3.
        do_reset();
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        serve(4'b1111, 1'b0, "all4");

        // Non-granted channels toggle garbage during channel 0 transfer.
        words[0] = 16'h1234;
        serve(4'b0001, 1'b1, "noise");

`ifdef DESER_ARB_TIMEOUT_EN
        // Channel 1 stalls after 5 bits; watchdog must abort 64 cycles later.
        bus.req_i = 4'b0010;
        wait_gnt(n);
        chk("to_gnt", 32'(bus.gnt_o), 32'h2);
        bus.req_i = '0;
        mptr = 2;
        send_bits(1, 16'hDEAD, 0, 5, 1'b0);
        n = 0;
        while (!bus.abort_o && n < 100) begin
            tick();
            n++;
        end
        chk("to_abort_lat", 32'(n), 32'(TO));
        chk("to_gnt_clr", 32'(bus.gnt_o), 32'd0);
        $display("abort: ch=1 cycles_after_bit5=%0d", n);
        tick();
        chk("to_abort_pulse", 32'(bus.abort_o), 32'd0);
        words[2] = 16'hFFFF;
        serve(4'b0100, 1'b0, "to_next");
`else
        // Channel 1 stalls 200 cycles mid-word, then completes without abort.
        words[1] = 16'h0F0F;
        bus.req_i = 4'b0010;
        wait_gnt(n);
        chk("stall_gnt", 32'(bus.gnt_o), 32'h2);
        bus.req_i = '0;
        mptr = 2;
        send_bits(1, words[1], 0, 8, 1'b0);
        aborts = 0;
        repeat (200) begin
            tick();
            if (bus.abort_o)
                aborts++;
        end
        chk("stall_no_abort", 32'(aborts), 32'd0);
        chk("stall_gnt_held", 32'(bus.gnt_o), 32'h2);
        send_bits(1, words[1], 8, 8, 1'b0);
        finish_word(1, words[1], "stall");
`endif

        // Reset in the middle of a channel 3 transfer discards the partial word.
        bus.req_i = 4'b1000;
        wait_gnt(n);
        chk("srst_gnt", 32'(bus.gnt_o), 32'h8);
        bus.req_i = '0;
        send_bits(3, 16'h5A5A, 0, 8, 1'b1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        mptr = 0;
        chk("srst_gnt_clr", 32'(bus.gnt_o), 32'd0);
        chk("srst_word", 32'(bus.word_o), 32'd0);
        chk("srst_ch", 32'(bus.word_ch_o), 32'd0);
        chk("srst_val", 32'(bus.word_val_o), 32'd0);
        chk("srst_abort", 32'(bus.abort_o), 32'd0);
        words[0] = 16'h8001; words[1] = 16'h7E7E; words[3] = 16'hC001;
        serve(4'b1011, 1'b0, "post_srst");

        // Randomized request sets and words against the round-robin model.
        for (int r = 0; r < 8; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int c = 0; c < N; c++)
                words[c] = 16'($urandom);
            serve(mask, 1'b1, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
